// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch-unit definitions: controller state encoding and instruction width.
package ifetch_ctrl_pkg;

   localparam int INST_W = 32;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous fetch queue, DEPTH entries; a push lands at the head no earlier than the next cycle.
// Accepts a push while full when a pop happens in the same cycle; flush empties it in one edge.
module ifetch_fifo #(
   parameter int W     = 42,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign head_dat = mem_q[rd_q];

   // Pop is qualified first so that a full queue can still take a push alongside it.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives an external combinational ROM, queues {word, pc} for decode.
// Head appears one cycle after fetch; fetch stalls while the queue is full and decode is not popping.
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter int          ROM_ADDR_BITS = 10,
   parameter int unsigned RESET_PC      = 0,
   parameter int          Q_DEPTH       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ROM_ADDR_BITS-1:0] mem_addr,
   input  logic [INST_W-1:0]        mem_data,
   input  logic                     redirect_valid,
   input  logic [ROM_ADDR_BITS-1:0] redirect_pc,
   input  logic                     halt_req,
   input  logic                     resume_req,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [INST_W-1:0]        inst_data,
   output logic [ROM_ADDR_BITS-1:0] inst_pc,
   output logic                     halted,
   output logic                     misalign_err
);

   localparam int ENTRY_W = INST_W + ROM_ADDR_BITS;
   localparam logic [ROM_ADDR_BITS-1:0] RESET_PC_A =
      ROM_ADDR_BITS'(RESET_PC) & ~ROM_ADDR_BITS'(3);

   fetch_state_e             state_q, state_d;
   logic [ROM_ADDR_BITS-1:0] pc_q, pc_d;
   logic                     misalign_q, misalign_d;

   logic               q_empty, q_full;
   logic               push, pop;
   logic [ENTRY_W-1:0] head_dat;

   // A redirect wins over everything: it flushes the queue and blocks this cycle's push and pop.
   assign inst_valid = ~q_empty;
   assign pop        = inst_valid & inst_ready & ~redirect_valid;
   assign push       = (state_q == ST_RUN) & ~redirect_valid & (~q_full | pop);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[ROM_ADDR_BITS-1:2], 2'b00};
         if (is_misaligned(redirect_pc[1:0])) misalign_d = 1'b1;
      end else begin
         if (push) pc_d = pc_q + ROM_ADDR_BITS'(4);
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: if (resume_req && !halt_req) state_d = ST_RUN;
            default: state_d = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC_A;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   ifetch_fifo #(
      .W     (ENTRY_W),
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push     (push),
      .push_dat ({mem_data, pc_q}),
      .pop      (pop),
      .head_dat (head_dat),
      .empty    (q_empty),
      .full     (q_full)
   );

   assign {inst_data, inst_pc} = head_dat;
   assign mem_addr             = pc_q;
   assign halted               = (state_q == ST_HALT) && q_empty;
   assign misalign_err         = misalign_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed + randomized bench for ifetch_ctrl against a queue-based behavioural model.
module tb_ifetch_ctrl;

   localparam int QD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        halt_req;
   logic        resume_req;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [9:0]  inst_pc;
   logic        halted;
   logic        misalign_err;

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model: pending pcs in fetch order, next fetch pc, mode flags.
   logic [9:0] mq[$];
   logic [9:0] mpc;
   bit         mboot, mstop, mmis;
   logic [9:0] frozen;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [9:0] a);
      return {6'h2A, a, 6'h15, ~a};
   endfunction

   assign mem_data = rom(mem_addr);

   ifetch_ctrl #(.ROM_ADDR_BITS(10), .RESET_PC(0), .Q_DEPTH(QD)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume_req     (resume_req),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .halted         (halted),
      .misalign_err   (misalign_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare outputs with the model, apply this cycle's inputs to the model, advance one clock.
   task automatic tick(input bit en);
      bit popping, pushing;
      if (en) begin
         chk("inst_valid", inst_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0]);
            chk("inst_data", inst_data, rom(mq[0]));
         end
         chk("mem_addr", mem_addr, mpc);
         chk("halted", halted, mstop && mq.size() == 0);
         chk("misalign_err", misalign_err, mmis);
      end
      if (rst) begin
         mq.delete();
         mpc   = 10'd0;
         mboot = 1'b1;
         mstop = 1'b0;
         mmis  = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         mpc = redirect_pc & 10'h3FC;
         if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
      end else begin
         popping = (mq.size() != 0) && inst_ready;
         pushing = !mboot && !mstop && ((int'(mq.size()) - int'(popping)) < QD);
         if (popping) void'(mq.pop_front());
         if (pushing) begin
            mq.push_back(mpc);
            mpc = mpc + 10'd4;
         end
         if (mboot) mboot = 1'b0;
         else if (!mstop && halt_req) mstop = 1'b1;
         else if (mstop && resume_req && !halt_req) mstop = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      halt_req = 1'b0; resume_req = 1'b0; inst_ready = 1'b1;
      tick(0); tick(0);
      rst = 1'b0;

      // Reset release and streaming fetch.
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 10'h000);
      chk("rst_misalign", misalign_err, 1'b0);
      chk("rst_halted", halted, 1'b0);
      tick(1);
      chk("boot_no_valid", inst_valid, 1'b0);
      tick(1);
      chk("first_valid", inst_valid, 1'b1);
      chk("seq_pc0", inst_pc, 10'h000);
      tick(1); chk("seq_pc4", inst_pc, 10'h004);
      tick(1); chk("seq_pc8", inst_pc, 10'h008);
      tick(1); chk("seq_pc12", inst_pc, 10'h00C);

      // Backpressure: queue fills to two entries and fetch stalls.
      rst = 1'b1; tick(1); rst = 1'b0;
      inst_ready = 1'b0;
      repeat (5) tick(1);
      chk("stall_mem_addr", mem_addr, 10'h008);
      chk("stall_head", inst_pc, 10'h000);
      inst_ready = 1'b1;
      tick(1); chk("drain_pc4", inst_pc, 10'h004);
      tick(1); chk("drain_pc8", inst_pc, 10'h008);

      // Redirect with a full queue.
      redirect_valid = 1'b1; redirect_pc = 10'h100;
      tick(1);
      redirect_valid = 1'b0;
      chk("redir_flush", inst_valid, 1'b0);
      chk("redir_mem_addr", mem_addr, 10'h100);
      tick(1);
      chk("redir_head", inst_pc, 10'h100);

      // Misaligned redirect.
      redirect_valid = 1'b1; redirect_pc = 10'h102;
      tick(1);
      redirect_valid = 1'b0;
      chk("mis_set", misalign_err, 1'b1);
      chk("mis_mem_addr", mem_addr, 10'h100);
      tick(1);
      chk("mis_head", inst_pc, 10'h100);

      // Address wrap at the top of the ROM.
      redirect_valid = 1'b1; redirect_pc = 10'h3F8;
      tick(1);
      redirect_valid = 1'b0;
      tick(1); chk("wrap_3f8", inst_pc, 10'h3F8);
      tick(1); chk("wrap_3fc", inst_pc, 10'h3FC);
      tick(1); chk("wrap_000", inst_pc, 10'h000);
      chk("mis_sticky", misalign_err, 1'b1);

      // Halt, drain, resume, then reset while halted.
      halt_req = 1'b1; tick(1); halt_req = 1'b0;
      repeat (3) tick(1);
      chk("halt_halted", halted, 1'b1);
      frozen = mpc;
      repeat (2) tick(1);
      chk("halt_frozen", mem_addr, frozen);
      resume_req = 1'b1; tick(1); resume_req = 1'b0;
      chk("resume_halted", halted, 1'b0);
      tick(1);
      chk("resume_pc", inst_pc, frozen);
      halt_req = 1'b1; tick(1); halt_req = 1'b0;
      repeat (3) tick(1);
      rst = 1'b1; resume_req = 1'b1; tick(1); rst = 1'b0; resume_req = 1'b0;
      chk("halt_rst_mem_addr", mem_addr, 10'h000);
      chk("halt_rst_halted", halted, 1'b0);
      chk("halt_rst_misalign", misalign_err, 1'b0);
      tick(1); tick(1);
      chk("halt_rst_restart", inst_pc, 10'h000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 10'($urandom_range(0, 1023));
         halt_req       = ($urandom_range(0, 9) == 0);
         resume_req     = ($urandom_range(0, 7) == 0);
         inst_ready     = ($urandom_range(0, 9) < 7);
         tick(1);
      end
      rst = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
      tick(1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 10, meaning byte-address width of the instruction memory port.
REQ-002 Parameter RESET_PC, default 0, meaning byte address fetched first after reset.
REQ-003 Parameter Q_DEPTH, default 2, meaning fetch-queue entries (power of two, at least 2).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_addr  output  ROM_ADDR_BITS  byte address to the instruction memory; bits [1:0] always 0.
REQ-007 mem_data  input  32  instruction word; combinational response to mem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; load new PC.
REQ-009 redirect_pc  input  ROM_ADDR_BITS  target byte address.
REQ-010 halt_req  input  1  stop issuing fetches.
REQ-011 resume_req  input  1  restart fetching from the current PC.
REQ-012 inst_valid  output  1  queue head valid toward decode.
REQ-013 inst_ready  input  1  decode accepts the head this cycle.
REQ-014 inst_data  output  32  queue-head instruction.
REQ-015 inst_pc  output  ROM_ADDR_BITS  queue-head byte address.
REQ-016 halted  output  1  FSM is in HALT and the queue is empty.
REQ-017 misalign_err  output  1  sticky; a redirect had redirect_pc[1:0] != 0.

Function
REQ-018 FSM states SHALL be BOOT, RUN and HALT: BOOT->RUN after one cycle; RUN->HALT when halt_req=1; HALT->RUN when resume_req=1 and halt_req=0.
REQ-019 In BOOT, no push SHALL occur; pc SHALL hold RESET_PC with bits [1:0] forced to 0.
REQ-020 mem_addr SHALL equal pc in every cycle.
REQ-021 In RUN, a push of {mem_data, pc} SHALL occur when the queue is not full, or is full and a pop occurs in the same cycle.
REQ-022 Each push SHALL advance pc by 4, wrapping from 2**ROM_ADDR_BITS-4 to 0.
REQ-023 In HALT, no push SHALL occur; pops continue; pc SHALL hold.
REQ-024 Pop occurs when inst_valid=1 and inst_ready=1; queue order is strictly FIFO.
REQ-025 inst_valid SHALL be 1 exactly when the queue is non-empty; inst_data and inst_pc are don't-care when inst_valid=0.
REQ-026 Latency: a word present on mem_data in cycle N SHALL appear at the queue head no earlier than cycle N+1.
REQ-027 Redirect SHALL have priority over push, pop, halt_req and resume_req.
REQ-028 On redirect, the queue SHALL be flushed, and no push or pop SHALL occur that cycle.
REQ-029 On redirect, pc SHALL load {redirect_pc[ROM_ADDR_BITS-1:2], 2'b00} next cycle, and inst_valid SHALL be 0 next cycle.
REQ-030 On redirect, the FSM state SHALL be unchanged; a redirect in HALT updates pc only.
REQ-031 misalign_err SHALL set on a redirect with redirect_pc[1:0] != 0, and clear only on rst.
REQ-032 halt_req and resume_req both high in RUN SHALL act as halt; in HALT they SHALL act as no-op.
REQ-033 halted SHALL be 1 only when state=HALT and the queue is empty.

Reset
REQ-034 While rst=1 at a clock edge, the following SHALL hold next cycle: state=BOOT, pc=RESET_PC (aligned), queue empty, inst_valid=0, misalign_err=0, halted=0, and mem_addr=RESET_PC.
REQ-035 rst mid-operation SHALL discard queued entries and override a simultaneous redirect, halt_req or resume_req.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (BOOT/RUN/HALT) and the instruction width constant (32).
REQ-037 The queue SHALL be one sub-module, ifetch_fifo: synchronous, width 32+ROM_ADDR_BITS, depth Q_DEPTH, with a flush input and simultaneous push/pop when full.
REQ-038 The instruction memory SHALL remain external; ifetch_ctrl SHALL contain no ROM array.

Verification
REQ-039 Reset release with RESET_PC=0 and inst_ready=1 -> inst_pc sequence 0,4,8,12; first inst_valid=1 at the second edge after rst falls.
REQ-040 inst_ready=0 for 5 cycles -> exactly 2 entries held (pc 0,4), mem_addr held at 8; then inst_ready=1 -> pops 0,4,8 with no gaps.
REQ-041 Redirect to 0x100 while the queue holds 2 entries -> next cycle inst_valid=0 and mem_addr=0x100; the following cycle inst_pc=0x100.
REQ-042 Redirect to 0x102 -> misalign_err=1, fetch resumes at 0x100, and misalign_err stays 1 until rst.
REQ-043 pc=0x3FC in RUN (ROM_ADDR_BITS=10) -> the next fetched inst_pc after 0x3FC is 0x000.
REQ-044 halt_req pulse with inst_ready=1 -> queue drains, halted=1, mem_addr frozen; resume_req pulse -> halted=0 and fetch continues from the frozen pc; rst asserted during HALT -> state BOOT, pc=RESET_PC.
